// File: rtl/final_soc_pkg.sv
// Shared types and constants for the result-delivery Avalon-MM initiator.
package final_soc_pkg;

  localparam int unsigned AVM_DATA_W = 32;
  localparam int unsigned RESULT_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDV,
    S_CHK,
    S_FIN,
    S_ERR
  } state_t;

endpackage

// File: rtl/final_soc_wait_timer.sv
// Up-counter bounding how long a bus command may stall; clear reloads zero.
module final_soc_wait_timer #(
  parameter int unsigned W     = 8,
  parameter int unsigned LIMIT = 254
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic en,
  output logic term
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign term = (count == W'(LIMIT));

endmodule

// File: rtl/final_soc_result_master.sv
// Avalon-MM initiator: writes each digit result to the result register,
// optionally reads it back, retries on mismatch and reports done/err.
module final_soc_result_master
  import final_soc_pkg::*;
#(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned TARGET_ADDR = 0,
  parameter int unsigned VERIFY      = 1,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  res_valid,
  input  logic [RESULT_W-1:0]   res_data,
  output logic                  res_ready,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_write,
  output logic                  avm_read,
  output logic [AVM_DATA_W-1:0] avm_writedata,
  input  logic                  avm_waitrequest,
  input  logic [AVM_DATA_W-1:0] avm_readdata,
  input  logic                  avm_readdatavalid,
  input  logic                  clear_err,
  output logic                  done,
  output logic                  err,
  output logic [RESULT_W-1:0]   last_result
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_t              state, next_state;
  logic [3:0]          retry;
  logic [RESULT_W-1:0] rdata_q;
  logic                tmo;
  logic                timer_en;
  logic                rdata_unused;

  // Only the digit bits of the read data take part in the comparison.
  assign rdata_unused = ^avm_readdata[AVM_DATA_W-1:RESULT_W];

  assign timer_en = (state == S_WR) || (state == S_RD) || (state == S_RDV);

  // Terminal fires in the TIMEOUT-th cycle spent in a waiting state.
  final_soc_wait_timer #(
    .W     (TW),
    .LIMIT (TIMEOUT - 1)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (next_state != state),
    .en      (timer_en),
    .term    (tmo)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (res_valid && res_ready) next_state = S_WR;
      S_WR: begin
        if (!avm_waitrequest) next_state = (VERIFY != 0) ? S_RD : S_FIN;
        else if (tmo)         next_state = S_ERR;
      end
      S_RD: begin
        if (!avm_waitrequest) next_state = avm_readdatavalid ? S_CHK : S_RDV;
        else if (tmo)         next_state = S_ERR;
      end
      S_RDV: begin
        if (avm_readdatavalid) next_state = S_CHK;
        else if (tmo)          next_state = S_ERR;
      end
      S_CHK: begin
        if (rdata_q == last_result)   next_state = S_FIN;
        else if (retry < 4'(MAX_RETRY)) next_state = S_WR;
        else                          next_state = S_ERR;
      end
      S_FIN:   next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Command strobes are registered from the next state so they track the state exactly.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      res_ready   <= 1'b1;
      avm_write   <= 1'b0;
      avm_read    <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      last_result <= '0;
      retry       <= '0;
      rdata_q     <= '0;
    end else begin
      res_ready <= (next_state == S_IDLE);
      avm_write <= (next_state == S_WR);
      avm_read  <= (next_state == S_RD);
      done      <= (state == S_FIN);
      if (state == S_IDLE && next_state == S_WR) begin
        last_result <= res_data;
        retry       <= '0;
      end
      if (state == S_CHK && next_state == S_WR) retry <= retry + 4'd1;
      if ((state == S_RD || state == S_RDV) && next_state == S_CHK)
        rdata_q <= avm_readdata[RESULT_W-1:0];
      if (next_state == S_ERR) err <= 1'b1;
      else if (clear_err)      err <= 1'b0;
    end
  end

  assign avm_address   = ADDR_W'(TARGET_ADDR);
  assign avm_writedata = {{(AVM_DATA_W - RESULT_W){1'b0}}, last_result};

endmodule

// File: tb/tb_final_soc_result_master.sv
// Directed bench: table of transactions against a scripted slave, plus
// hand sequences for reset, timeout, late readdatavalid and a write-only build.
module tb_final_soc_result_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        res_valid = 1'b0;
  logic [3:0]  res_data = '0;
  logic        res_ready;
  logic [3:0]  avm_address;
  logic        avm_write, avm_read;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        clear_err = 1'b0;
  logic        done, err;
  logic [3:0]  last_result;

  logic        res_valid2 = 1'b0;
  logic        res_ready2, write2, read2, done2, err2;
  logic [3:0]  address2, last_result2;
  logic [31:0] writedata2;
  logic        wait2 = 1'b0;
  logic        rdv2 = 1'b0;
  logic [31:0] readdata2 = '0;
  logic        clear_err2 = 1'b0;

  always #5 clk = ~clk;

  final_soc_result_master #(
    .ADDR_W(4), .TARGET_ADDR(0), .VERIFY(1), .MAX_RETRY(3), .TIMEOUT(255)
  ) dut (
    .clk(clk), .reset_n(reset_n), .res_valid(res_valid), .res_data(res_data),
    .res_ready(res_ready), .avm_address(avm_address), .avm_write(avm_write),
    .avm_read(avm_read), .avm_writedata(avm_writedata),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .clear_err(clear_err),
    .done(done), .err(err), .last_result(last_result)
  );

  final_soc_result_master #(
    .ADDR_W(4), .TARGET_ADDR(0), .VERIFY(0), .MAX_RETRY(3), .TIMEOUT(255)
  ) dut_nv (
    .clk(clk), .reset_n(reset_n), .res_valid(res_valid2), .res_data(4'd6),
    .res_ready(res_ready2), .avm_address(address2), .avm_write(write2),
    .avm_read(read2), .avm_writedata(writedata2),
    .avm_waitrequest(wait2), .avm_readdata(readdata2),
    .avm_readdatavalid(rdv2), .clear_err(clear_err2),
    .done(done2), .err(err2), .last_result(last_result2)
  );

  // Slave behaviour knobs (written only by the test process)
  int          wr_stall = 0;
  bit          stuck = 1'b0;
  bit          resp_en = 1'b1;
  bit          zl = 1'b0;
  bit          force_rdv = 1'b0;
  logic [31:0] exp_wdata = '0;

  // Slave state and cumulative monitors (written only by the slave process)
  int stall_cnt = 0;
  bit pend = 1'b0;
  bit acc_rd;
  int wcyc = 0, wacc = 0, racc = 0, dcnt = 0, pbad = 0, nvrd = 0, nvbad = 0;

  always @(negedge clk) begin
    if (stuck) avm_waitrequest = 1'b1;
    else if (avm_write && stall_cnt < wr_stall) begin
      avm_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      avm_waitrequest = 1'b0;
      stall_cnt = 0;
    end
    acc_rd = avm_read && !avm_waitrequest;
    avm_readdatavalid = force_rdv || (resp_en && (zl ? acc_rd : pend));
    pend = acc_rd;
    if (avm_write) wcyc++;
    if (avm_write && !avm_waitrequest) wacc++;
    if (acc_rd) racc++;
    if (done) dcnt++;
    if (avm_write && (avm_writedata != exp_wdata || avm_address != 4'd0)) pbad++;
    if (avm_write && avm_read) pbad++;
    if (read2) nvrd++;
    if (write2 && (writedata2 != 32'd6 || address2 != 4'd0)) nvbad++;
  end

  int n_tests = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [3:0] data;
    logic [3:0] rd_val;
    int         stall;
    bit         zl;
    int         exp_wr;
    int         exp_wcyc;
    int         exp_rd;
    int         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    int s_wcyc, s_wacc, s_racc, s_dcnt, s_pbad;
    bit ok;
    exp_wdata = {28'h0, v.data};
    wr_stall = v.stall;
    zl = v.zl;
    resp_en = 1'b1;
    avm_readdata = {28'h1234567, v.rd_val};
    s_wcyc = wcyc; s_wacc = wacc; s_racc = racc; s_dcnt = dcnt; s_pbad = pbad;
    res_data = v.data;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (res_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk($sformatf("v%0d_return_idle", idx), 32'(ok), 32'd1);
    tick();
    tick();
    chk($sformatf("v%0d_writes", idx), 32'(wacc - s_wacc), 32'(v.exp_wr));
    chk($sformatf("v%0d_write_cycles", idx), 32'(wcyc - s_wcyc), 32'(v.exp_wcyc));
    chk($sformatf("v%0d_reads", idx), 32'(racc - s_racc), 32'(v.exp_rd));
    chk($sformatf("v%0d_done", idx), 32'(dcnt - s_dcnt), 32'(v.exp_done));
    chk($sformatf("v%0d_err", idx), 32'(err), 32'(v.exp_err));
    chk($sformatf("v%0d_last_result", idx), 32'(last_result), 32'(v.data));
    chk($sformatf("v%0d_protocol", idx), 32'(pbad - s_pbad), 32'd0);
    if (v.exp_err) begin
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk($sformatf("v%0d_clear_err", idx), 32'(err), 32'd0);
    end
  endtask

  initial begin
    int s_wcyc, s_dcnt, s_wacc;
    bit ok;

    vecs[0] = '{4'd7,  4'd7,  0, 1'b0, 1, 1, 1, 1, 1'b0};
    vecs[1] = '{4'd5,  4'd5,  5, 1'b0, 1, 6, 1, 1, 1'b0};
    vecs[2] = '{4'd9,  4'd3,  0, 1'b0, 4, 4, 4, 0, 1'b1};
    vecs[3] = '{4'd2,  4'd2,  0, 1'b1, 1, 1, 1, 1, 1'b0};
    vecs[4] = '{4'd15, 4'd15, 2, 1'b0, 1, 3, 1, 1, 1'b0};
    vecs[5] = '{4'd0,  4'd8,  0, 1'b1, 4, 4, 4, 0, 1'b1};

    // Reset held with a valid result pending
    res_valid = 1'b1;
    res_data  = 4'd4;
    tick(); tick(); tick();
    chk("rst_write", 32'(avm_write), 32'd0);
    chk("rst_read", 32'(avm_read), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_last_result", 32'(last_result), 32'd0);
    chk("rst_res_ready", 32'(res_ready), 32'd1);
    chk("rst_no_cmd", 32'(wcyc + racc), 32'd0);
    res_valid = 1'b0;
    reset_n = 1'b1;
    tick();

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Write stuck behind waitrequest until the timeout fires
    stuck = 1'b1;
    exp_wdata = 32'd6;
    s_wcyc = wcyc; s_dcnt = dcnt;
    res_data = 4'd6;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (res_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("tmo_return_idle", 32'(ok), 32'd1);
    chk("tmo_write_cycles", 32'(wcyc - s_wcyc), 32'd255);
    chk("tmo_err", 32'(err), 32'd1);
    chk("tmo_write_low", 32'(avm_write), 32'd0);
    stuck = 1'b0;
    tick();
    chk("tmo_no_done", 32'(dcnt - s_dcnt), 32'd0);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("tmo_clear_err", 32'(err), 32'd0);

    // Reset while waiting for read data; the late readdatavalid must be ignored
    resp_en = 1'b0;
    zl = 1'b0;
    wr_stall = 0;
    exp_wdata = 32'd8;
    avm_readdata = 32'd8;
    res_data = 4'd8;
    res_valid = 1'b1;
    tick();
    res_valid = 1'b0;
    chk("rdv_in_wr", 32'(avm_write), 32'd1);
    tick();
    chk("rdv_in_rd", 32'(avm_read), 32'd1);
    tick();
    chk("rdv_read_dropped", 32'(avm_read), 32'd0);
    chk("rdv_busy", 32'(res_ready), 32'd0);
    reset_n = 1'b0;
    tick();
    chk("rdv_rst_idle", 32'(res_ready), 32'd1);
    chk("rdv_rst_last", 32'(last_result), 32'd0);
    reset_n = 1'b1;
    s_dcnt = dcnt; s_wacc = wacc;
    force_rdv = 1'b1;
    tick(); tick();
    force_rdv = 1'b0;
    tick(); tick();
    chk("rdv_late_no_done", 32'(dcnt - s_dcnt), 32'd0);
    chk("rdv_late_no_write", 32'(wacc - s_wacc), 32'd0);
    chk("rdv_late_err", 32'(err), 32'd0);
    chk("rdv_late_idle", 32'(res_ready), 32'd1);

    // Write-only build: done three cycles after the accept cycle, never a read
    res_valid2 = 1'b1;
    tick();
    res_valid2 = 1'b0;
    chk("nv_write_c1", 32'(write2), 32'd1);
    chk("nv_done_c1", 32'(done2), 32'd0);
    tick();
    chk("nv_write_c2", 32'(write2), 32'd0);
    chk("nv_done_c2", 32'(done2), 32'd0);
    tick();
    chk("nv_done_c3", 32'(done2), 32'd1);
    chk("nv_last_result", 32'(last_result2), 32'd6);
    tick();
    chk("nv_done_c4", 32'(done2), 32'd0);
    chk("nv_ready", 32'(res_ready2), 32'd1);
    chk("nv_err", 32'(err2), 32'd0);
    chk("nv_never_read", 32'(nvrd), 32'd0);
    chk("nv_writedata", 32'(nvbad), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
